// File: rtl/spi_display_receiver.sv
`timescale 1ns/1ps
// SPI slave receiver for a display link: synchronizes the SPI pins into the clk
// domain, assembles MSB-first words tagged with dc, and queues them in a FIFO.
module spi_display_receiver #(
  parameter int dataBits  = 8,
  parameter int fifoDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs,
  input  logic                dc,
  output logic [dataBits-1:0] rxData,
  output logic                rxDc,
  output logic                rxValid,
  input  logic                rxReady,
  output logic                overflow,
  output logic                frameError,
  output logic                busy
);

  localparam int BW = (dataBits > 1) ? $clog2(dataBits) : 1;
  localparam int PW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CW = $clog2(fifoDepth + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(dataBits - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(fifoDepth);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Pin synchronizers; cs resets high so the link looks deselected.
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] cs_sync;
  logic [1:0] dc_sync;
  logic       sclk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      dc_sync   <= {dc_sync[0], dc};
      sclk_prev <= sclk_sync[1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic dc_s;
  logic sclk_rise;

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_s      = cs_sync[1];
  assign dc_s      = dc_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  state_t             state;
  state_t             state_next;
  logic [BW-1:0]      bit_count;
  logic [dataBits-2:0] shift_reg;
  logic [dataBits-1:0] shift_next;
  logic               shift_en;
  logic               push;
  logic               frame_abort;
  logic               clear_count;

  assign shift_next = {shift_reg, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    push        = 1'b0;
    frame_abort = 1'b0;
    clear_count = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_next  = SHIFT;
          clear_count = 1'b1;
        end
      end
      SHIFT: begin
        // Deselect wins over a coincident sclk edge.
        if (cs_s) begin
          state_next  = IDLE;
          clear_count = 1'b1;
          frame_abort = (bit_count != '0);
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          push     = (bit_count == LAST_BIT);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count  <= '0;
      shift_reg  <= '0;
      frameError <= 1'b0;
    end else begin
      frameError <= frame_abort;
      if (clear_count) begin
        bit_count <= '0;
        shift_reg <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_next[dataBits-2:0];
        bit_count <= push ? '0 : bit_count + BW'(1);
      end
    end
  end

  assign busy = (state == SHIFT);

  // Receive FIFO: entry = {dc, word}; occupancy count separates full from empty.
  logic [dataBits:0] mem [fifoDepth];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic [dataBits:0] head;

  assign full  = (count == FULL_COUNT);
  assign pop   = rxValid & rxReady;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {dc_s, shift_next};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign rxValid = (count != '0);
  assign rxData  = rxValid ? head[dataBits-1:0] : '0;
  assign rxDc    = rxValid & head[dataBits];

endmodule

// File: tb/tb_spi_display_receiver.sv
`timescale 1ns/1ps
// Directed bench for spi_display_receiver: bit-banged SPI frames with
// hand-computed expected words, checked by immediate assertions.
module tb_spi_display_receiver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         mosi;
  logic         cs;
  logic         dc;
  logic         rxReady;
  logic [W-1:0] rxData;
  logic         rxDc;
  logic         rxValid;
  logic         overflow;
  logic         frameError;
  logic         busy;

  int checks   = 0;
  int errors   = 0;
  int fe_count = 0;
  int fe_before;
  int last_lat;

  logic [W:0] got_q[$];
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  spi_display_receiver #(.dataBits(W), .fifoDepth(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs         (cs),
    .dc         (dc),
    .rxData     (rxData),
    .rxDc       (rxDc),
    .rxValid    (rxValid),
    .rxReady    (rxReady),
    .overflow   (overflow),
    .frameError (frameError),
    .busy       (busy)
  );

  // Record every accepted word and every cycle frameError is high.
  always @(negedge clk) begin
    if (frameError) fe_count++;
    if (rxValid && rxReady) got_q.push_back({rxDc, rxData});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send the top n bits of word, 4 clk low / 4 clk high per bit. last_lat is the
  // clk count from the final sclk rise to rxValid rising (-1 if it did not).
  // arm raises rxReady two clk after the final rise, the cycle of the push.
  task automatic send_bits(input logic [W-1:0] word, input int n, input logic arm);
    logic was_valid;
    was_valid = 1'b1;
    last_lat  = -1;
    for (int i = 0; i < n; i++) begin
      mosi = word[W-1-i];
      tick(4);
      was_valid = rxValid;
      sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        tick(1);
        if (i == n - 1) begin
          if (k == 2 && arm) rxReady = 1'b1;
          if (last_lat < 0 && !was_valid && rxValid) last_lat = k;
        end
      end
      sclk = 1'b0;
    end
    for (int k = 5; k <= 8; k++) begin
      tick(1);
      if (last_lat < 0 && !was_valid && rxValid) last_lat = k;
    end
  endtask

  task automatic start_frame();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    tick(4);
  endtask

  task automatic drain();
    rxReady = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (!rxValid) break;
    end
    rxReady = 1'b0;
    tick(1);
    check("drain_empty", rxValid, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0; rxReady = 1'b0;
    tick(3);
    check("rst_rxValid", rxValid, 1'b0);
    check("rst_rxData", rxData, 8'h00);
    check("rst_rxDc", rxDc, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frameError", frameError, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(3);

    // Single word 0xA5, command, held in the FIFO.
    start_frame();
    check("a5_busy", busy, 1'b1);
    dc = 1'b0;
    send_bits(8'hA5, 8, 1'b0);
    check("a5_latency_le5", (last_lat >= 1 && last_lat <= 5), 1'b1);
    check("a5_rxValid", rxValid, 1'b1);
    check("a5_rxData", rxData, 8'hA5);
    check("a5_rxDc", rxDc, 1'b0);
    end_frame();
    check("a5_idle_busy", busy, 1'b0);
    got_q.delete();
    drain();
    exp_q.delete(); exp_q.push_back(9'h0A5);
    check_q("a5_pop");
    check("empty_rxData", rxData, 8'h00);
    check("empty_rxDc", rxDc, 1'b0);

    // Three words in one frame with per-word dc, consumer always ready.
    got_q.delete();
    fe_before = fe_count;
    rxReady = 1'b1;
    start_frame();
    dc = 1'b0; send_bits(8'h2A, 8, 1'b0);
    dc = 1'b1; send_bits(8'h00, 8, 1'b0);
    dc = 1'b1; send_bits(8'h7F, 8, 1'b0);
    end_frame();
    rxReady = 1'b0;
    exp_q.delete();
    exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h17F);
    check_q("three_words");
    check("three_no_frameError", fe_count - fe_before, 0);

    // Partial word aborted by cs, then a clean word.
    fe_before = fe_count;
    dc = 1'b0;
    start_frame();
    send_bits(8'hFF, 3, 1'b0);
    cs = 1'b1;
    tick(6);
    check("abort_fe_one_cycle", fe_count - fe_before, 1);
    check("abort_nothing_pushed", rxValid, 1'b0);
    check("abort_busy", busy, 1'b0);
    got_q.delete();
    start_frame();
    send_bits(8'h3C, 8, 1'b0);
    end_frame();
    drain();
    exp_q.delete(); exp_q.push_back(9'h03C);
    check_q("after_abort");
    check("after_abort_fe", fe_count - fe_before, 1);

    // Full FIFO, fifth word lands on the same cycle as a pop.
    got_q.delete();
    dc = 1'b1;
    start_frame();
    for (int i = 1; i <= 4; i++) send_bits(W'(i), 8, 1'b0);
    check("full_rxValid", rxValid, 1'b1);
    check("full_head", rxData, 8'h01);
    send_bits(8'h05, 8, 1'b1);
    tick(4);
    rxReady = 1'b0;
    end_frame();
    check("pushpop_overflow", overflow, 1'b0);
    check("pushpop_empty", rxValid, 1'b0);
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back({1'b1, W'(i)});
    check_q("pushpop_order");

    // Overflow: fifth word dropped with no consumer.
    got_q.delete();
    dc = 1'b0;
    start_frame();
    for (int i = 1; i <= 4; i++) send_bits(W'(i), 8, 1'b0);
    check("ovf_before", overflow, 1'b0);
    send_bits(8'h05, 8, 1'b0);
    check("ovf_set", overflow, 1'b1);
    end_frame();
    check("ovf_head", rxData, 8'h01);
    drain();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, W'(i)});
    check_q("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-word with two words queued and overflow set.
    start_frame();
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    check("pre_rst_valid", rxValid, 1'b1);
    check("pre_rst_overflow", overflow, 1'b1);
    send_bits(8'h33, 5, 1'b0);
    fe_before = fe_count;
    reset = 1'b1; cs = 1'b1; sclk = 1'b0;
    tick(2);
    check("mid_rst_rxValid", rxValid, 1'b0);
    check("mid_rst_rxData", rxData, 8'h00);
    check("mid_rst_rxDc", rxDc, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_frameError", frameError, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(4);
    check("post_rst_no_fe", fe_count - fe_before, 0);
    check("post_rst_empty", rxValid, 1'b0);
    got_q.delete();
    dc = 1'b1;
    start_frame();
    send_bits(8'h81, 8, 1'b0);
    end_frame();
    drain();
    exp_q.delete(); exp_q.push_back(9'h181);
    check_q("post_rst_word");
    check("post_rst_overflow", overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_display_receiver.md
SPI_DISPLAY_RECEIVER -- requirements
Module: spi_display_receiver

Interface
REQ-001 Parameter: dataBits, default 8, number of bits per received word.
REQ-002 Parameter: fifoDepth, default 4, number of receive FIFO entries (power of two, at least 2).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 sclk  input  1  serial clock from the display-side SPI master; asynchronous to clk.
REQ-006 mosi  input  1  serial data; master changes it on sclk falling edge, MSB first.
REQ-007 cs  input  1  chip select, active-low.
REQ-008 dc  input  1  data/command flag (1 = data, 0 = command).
REQ-009 rxData  output  dataBits  word at the FIFO head.
REQ-010 rxDc  output  1  dc value captured with the head word.
REQ-011 rxValid  output  1  FIFO non-empty.
REQ-012 rxReady  input  1  consumer accepts the head word when high with rxValid.
REQ-013 overflow  output  1  sticky flag: a completed word was dropped.
REQ-014 frameError  output  1  one-clk pulse: cs deasserted with a partial word.
REQ-015 busy  output  1  high while the FSM is in SHIFT.

Function
REQ-016 sclk, mosi, cs and dc SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-017 A sclk rising edge SHALL be detected when synchronized sclk is 1 and its previous-cycle value was 0 (sclkRise), exactly one clk cycle per edge.
REQ-018 The input contract is sclk high and low phases of at least 3 clk cycles each; behaviour outside that range is undefined.
REQ-019 FSM states: IDLE and SHIFT; IDLE->SHIFT when synchronized cs is 0; SHIFT->IDLE when synchronized cs is 1.
REQ-020 In SHIFT on sclkRise: shift register <= {shift[dataBits-2:0], mosi_sync}; bitCount increments.
REQ-021 bitCount SHALL be 0 on entry to SHIFT and SHALL wrap from dataBits-1 to 0 when a word completes.
REQ-022 On the sclkRise that completes bit dataBits-1: the word {shift, mosi_sync} and dc_sync SHALL be pushed to the FIFO on the next clk edge.
REQ-023 rxValid SHALL rise on the clk cycle after the push; end-to-end latency SHALL be at most 5 clk cycles from the raw sclk edge.
REQ-024 Back-to-back words within one cs-low frame SHALL be received without gaps; dc SHALL be sampled per word.
REQ-025 Pop occurs when rxValid and rxReady are both 1; the head advances on that clk edge.
REQ-026 While the FIFO is empty: rxValid=0, rxData=0, rxDc=0.
REQ-027 Push when the FIFO is full and no pop occurs in that cycle: the word is dropped, contents are unchanged, and overflow is set.
REQ-028 Push and pop in the same cycle while full: both succeed, and occupancy stays at fifoDepth.
REQ-029 Push and pop in the same cycle while holding one entry: the new word becomes the head, and rxValid stays 1.
REQ-030 FIFO pointers SHALL wrap modulo fifoDepth, with full and empty distinguished by an occupancy count of 0..fifoDepth.
REQ-031 cs deasserting while 1 <= bitCount <= dataBits-1: discard the partial word, pulse frameError for 1 cycle, go to IDLE; FIFO contents are retained.
REQ-032 cs deasserting with bitCount=0: no error; go to IDLE.
REQ-033 sclkRise events in IDLE SHALL be ignored.

Reset
REQ-034 While reset=1: FSM=IDLE, bitCount=0, shift register=0, FIFO empty, rxValid=0, rxData=0, rxDc=0, overflow=0, frameError=0, busy=0, synchronizer flops=cs:1, others:0.
REQ-035 Reset asserted mid-word or mid-frame SHALL abort the word with no frameError; after release, reception begins at the next cs falling edge.
REQ-036 overflow SHALL clear only on reset.

Verification
REQ-037 cs low, dc=0, send 0xA5 (sclk period 8 clk), rxReady=0 -> rxValid=1 within 5 clk of the 8th sclk rise; rxData=0xA5, rxDc=0.
REQ-038 One frame: 0x2A with dc=0, then 0x00, 0x7F with dc=1; rxReady=1 -> three pops in order with (0x2A,0), (0x00,1), (0x7F,1); frameError never pulses.
REQ-039 rxReady=0, send 5 words 0x01..0x05 -> FIFO holds 0x01..0x04; overflow=1 after the 5th word; draining yields 0x01..0x04, then rxValid=0.
REQ-040 FIFO full, rxReady=1 held, 5th word 0x05 completes on the same cycle as a pop -> overflow stays 0, and the drain order is 0x01..0x05.
REQ-041 cs raised after 3 bits of 0xFF -> frameError is a 1-cycle pulse, nothing is pushed; the next full word 0x3C is received intact.
REQ-042 Reset pulsed after 5 bits, with 2 words queued and overflow=1 -> all outputs return to REQ-034 values; the next frame 0x81 is received correctly.
